// File: rtl/image_capture_window.sv
// Captures one WIN_W x WIN_H window of a pixel stream; Avalon-MM readout.
// Define IMAGE_CAPTURE_PACK_EN to pack floor(32/PIX_W) pixels per DATA read.
module image_capture_window #(
    parameter int WIN_W   = 224,
    parameter int WIN_H   = 224,
    parameter int X0      = 208,
    parameter int Y0      = 128,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 11
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 addr,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic [PIX_W+2*COORD_W:0]   INDATA_export
);

    localparam int DEPTH = WIN_W * WIN_H;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [COORD_W-1:0] XL = COORD_W'(X0);
    localparam logic [COORD_W-1:0] XR = COORD_W'(X0 + WIN_W - 1);
    localparam logic [COORD_W-1:0] YT = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] YB = COORD_W'(Y0 + WIN_H - 1);
    localparam logic [PTR_W-1:0]   LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]   WW   = PTR_W'(WIN_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Reset asserts asynchronously but releases on clk.
    logic [1:0] rst_sync_q;
    logic       rst_n_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_s = rst_sync_q[1];

    logic               in_pclk;
    logic [PIX_W-1:0]   in_pix;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;

    assign {in_pclk, in_pix, in_x, in_y} = INDATA_export;

    logic [2:0]         sync_q;
    logic               pix_stb;
    logic               vld_q;
    logic [PIX_W-1:0]   pix_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    assign pix_stb = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync_q <= '0;
            vld_q  <= 1'b0;
            pix_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            sync_q <= {sync_q[1:0], in_pclk};
            vld_q  <= pix_stb;
            if (pix_stb) begin
                pix_q <= in_pix;
                x_q   <= in_x;
                y_q   <= in_y;
            end
        end
    end

    logic             hit;
    logic             at_first;
    logic             at_last;
    logic [PTR_W-1:0] widx;

    assign hit      = (x_q >= XL) && (x_q <= XR) && (y_q >= YT) && (y_q <= YB);
    assign at_first = (x_q == XL) && (y_q == YT);
    assign at_last  = (x_q == XR) && (y_q == YB);
    assign widx     = PTR_W'(y_q - YT) * WW + PTR_W'(x_q - XL);

    logic ctrl_wr;
    logic ptr_wr;
    logic data_rd;

    assign ctrl_wr = wr_en && (addr == 2'd1);
    assign ptr_wr  = wr_en && (addr == 2'd2);
    assign data_rd = rd_en && !wr_en && (addr == 2'd0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        if (ctrl_wr && writedata[1]) begin
            state_d = IDLE;
        end else if (ctrl_wr && writedata[0]) begin
            state_d = ARMED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (vld_q && at_first) begin
                        mem_we  = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = at_last ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vld_q && hit) begin
                        mem_we = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (at_last) state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [PIX_W-1:0] pix_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) pix_mem[widx] <= pix_q;
    end

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] ptr_inc;
    logic [31:0]      data_word;

`ifdef IMAGE_CAPTURE_PACK_EN
    localparam int NPK = 32 / PIX_W;

    logic [PTR_W:0] lane_idx;
    logic [PTR_W:0] ptr_sum;

    always_comb begin
        data_word = '0;
        lane_idx  = '0;
        for (int i = 0; i < NPK; i++) begin
            lane_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (lane_idx < (PTR_W+1)'(DEPTH))
                data_word[i*PIX_W +: PIX_W] = pix_mem[lane_idx[PTR_W-1:0]];
        end
    end

    assign ptr_sum = {1'b0, ptr_q} + (PTR_W+1)'(NPK);
    assign ptr_inc = (ptr_sum >= (PTR_W+1)'(DEPTH))
                   ? PTR_W'(ptr_sum - (PTR_W+1)'(DEPTH))
                   : ptr_sum[PTR_W-1:0];
`else
    assign data_word = 32'(pix_mem[ptr_q]);
    assign ptr_inc   = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (ptr_wr)       ptr_d = PTR_W'(writedata % 32'(DEPTH));
        else if (data_rd) ptr_d = ptr_inc;
    end

    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            unique case (addr)
                2'd0: rdata_d = data_word;
                2'd1: rdata_d = {30'b0, state_q};
                2'd2: rdata_d = 32'(ptr_q);
                2'd3: rdata_d = 32'(cnt_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_image_capture_window.sv
// Directed bench for image_capture_window on a reduced 8x4 window at (208,128).
// Frames sweep X 204..219 over a chosen Y range with pixel = (X+Y+bias)&0xFF.
module tb_image_capture_window;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 11;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [1:0]               addr;
    logic                     rd_en;
    logic                     wr_en;
    logic [31:0]              writedata;
    logic [31:0]              readdata;
    logic [PIX_W+2*COORD_W:0] indata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    image_capture_window #(
        .WIN_W   (8),
        .WIN_H   (4),
        .X0      (208),
        .Y0      (128),
        .PIX_W   (PIX_W),
        .COORD_W (COORD_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr          (addr),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .writedata     (writedata),
        .readdata      (readdata),
        .INDATA_export (indata)
    );

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wr_en = 1'b1; writedata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = readdata;
    endtask

    task automatic send_pixel(input int x, input int y, input int p);
        @(negedge clk);
        indata = {1'b1, PIX_W'(p), COORD_W'(x), COORD_W'(y)};
        repeat (2) @(negedge clk);
        indata[PIX_W+2*COORD_W] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int ys, input int ye, input int bias);
        for (int y = ys; y <= ye; y++)
            for (int x = 204; x <= 219; x++)
                send_pixel(x, y, (x + y + bias) & 8'hFF);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL reset_state got %0h exp 0", r);
        end
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL reset_ptr got %0h exp 0", r);
        end
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL reset_cnt got %0h exp 0", r);
        end
        @(negedge clk);
        checks++;
        if (readdata !== 32'd0) begin
            failures++; $display("FAIL idle_rdata got %0h exp 0", readdata);
        end
    endtask

    task automatic test_capture();
        logic [31:0] r;
        bus_write(2'd1, 32'd1);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd1) begin
            failures++; $display("FAIL armed_state got %0h exp 1", r);
        end
        send_frame(126, 133, 0);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd3) begin
            failures++; $display("FAIL done_state got %0h exp 3", r);
        end
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd32) begin
            failures++; $display("FAIL full_cnt got %0d exp 32", r);
        end
    endtask

    task automatic test_data_read();
        logic [31:0] r;
        bus_write(2'd2, 32'd0);
`ifdef IMAGE_CAPTURE_PACK_EN
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h53525150) begin
            failures++; $display("FAIL pack_data got %0h exp 53525150", r);
        end
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd4) begin
            failures++; $display("FAIL pack_ptr got %0d exp 4", r);
        end
`else
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h50) begin
            failures++; $display("FAIL data0 got %0h exp 50", r);
        end
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h51) begin
            failures++; $display("FAIL data1 got %0h exp 51", r);
        end
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h52) begin
            failures++; $display("FAIL data2 got %0h exp 52", r);
        end
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd3) begin
            failures++; $display("FAIL ptr_inc got %0d exp 3", r);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] r;
`ifdef IMAGE_CAPTURE_PACK_EN
        bus_write(2'd2, 32'd30);
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h00005A59) begin
            failures++; $display("FAIL pack_end got %0h exp 5a59", r);
        end
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd2) begin
            failures++; $display("FAIL pack_wrap got %0d exp 2", r);
        end
`else
        bus_write(2'd2, 32'd31);
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h5A) begin
            failures++; $display("FAIL last_pix got %0h exp 5a", r);
        end
        bus_read(2'd0, r);
        checks++;
        if (r !== 32'h50) begin
            failures++; $display("FAIL wrap_pix got %0h exp 50", r);
        end
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd1) begin
            failures++; $display("FAIL wrap_ptr got %0d exp 1", r);
        end
`endif
        bus_write(2'd2, 32'd33);
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd1) begin
            failures++; $display("FAIL ptr_mod got %0d exp 1", r);
        end
    endtask

    task automatic test_midframe_arm();
        logic [31:0] r;
        bus_write(2'd1, 32'd1);
        send_frame(130, 133, 1);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd1) begin
            failures++; $display("FAIL mid_state got %0h exp 1", r);
        end
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL mid_cnt got %0d exp 0", r);
        end
        send_frame(126, 133, 1);
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd32) begin
            failures++; $display("FAIL recap_cnt got %0d exp 32", r);
        end
        bus_write(2'd2, 32'd0);
        bus_read(2'd0, r);
        checks++;
`ifdef IMAGE_CAPTURE_PACK_EN
        if (r !== 32'h54535251) begin
            failures++; $display("FAIL recap_data got %0h exp 54535251", r);
        end
`else
        if (r !== 32'h51) begin
            failures++; $display("FAIL recap_data got %0h exp 51", r);
        end
`endif
    endtask

    task automatic test_abort();
        logic [31:0] r;
        bus_write(2'd1, 32'd1);
        send_frame(126, 129, 2);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd2) begin
            failures++; $display("FAIL cap_state got %0h exp 2", r);
        end
        bus_write(2'd1, 32'd3);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL abort_state got %0h exp 0", r);
        end
        send_frame(130, 131, 2);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL idle_hold got %0h exp 0", r);
        end
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd16) begin
            failures++; $display("FAIL abort_cnt got %0d exp 16", r);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] r;
        bus_write(2'd2, 32'd5);
        @(negedge clk);
        addr = 2'd2; rd_en = 1'b1; wr_en = 1'b1; writedata = 32'd9;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if (readdata !== 32'd5) begin
            failures++; $display("FAIL rw_ptr got %0d exp 5", readdata);
        end
        @(negedge clk);
        addr = 2'd0; rd_en = 1'b1; wr_en = 1'b1; writedata = 32'd0;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
`ifdef IMAGE_CAPTURE_PACK_EN
        if (readdata !== 32'h57565554) begin
            failures++; $display("FAIL rw_data got %0h exp 57565554", readdata);
        end
`else
        if (readdata !== 32'h54) begin
            failures++; $display("FAIL rw_data got %0h exp 54", readdata);
        end
`endif
        bus_read(2'd2, r);
        checks++;
        if (r !== 32'd9) begin
            failures++; $display("FAIL rw_noinc got %0d exp 9", r);
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [31:0] r;
        bus_write(2'd1, 32'd1);
        send_frame(126, 128, 0);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd2) begin
            failures++; $display("FAIL part_state got %0h exp 2", r);
        end
        @(negedge clk);
        addr = 2'd3; rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        checks++;
        if (readdata !== 32'd8) begin
            failures++; $display("FAIL part_cnt got %0d exp 8", readdata);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin
            failures++; $display("FAIL async_rst got %0h exp 0", readdata);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(2'd3, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL rst_cnt got %0d exp 0", r);
        end
        send_frame(126, 133, 0);
        bus_read(2'd1, r);
        checks++;
        if (r !== 32'd0) begin
            failures++; $display("FAIL noarm_state got %0h exp 0", r);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        addr      = 2'd0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        writedata = 32'd0;
        indata    = '0;
        test_reset();
        test_capture();
        test_data_read();
        test_wrap();
        test_midframe_arm();
        test_abort();
        test_same_cycle();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
